// File: rtl/bcd_updown_counter_pkg.sv
// Shared BCD constants and helpers for the up/down decade counter.
// Vectors are carried at the widest legal size (eight decades) and zero-padded.
package bcd_cnt_pkg;

  localparam int              BCD_W         = 4;
  localparam logic [BCD_W-1:0] BCD_DIGIT_MAX = 4'd9;
  localparam int              MAX_DIGITS    = 8;
  localparam int              BCD_VEC_W     = BCD_W * MAX_DIGITS;

  // Decimal integer to packed BCD, least significant decade in bits [3:0].
  function automatic logic [BCD_VEC_W-1:0] to_bcd(input int value, input int digits);
    logic [BCD_VEC_W-1:0] r;
    int v;
    r = '0;
    v = value;
    for (int i = 0; i < MAX_DIGITS; i++) begin
      if (i < digits) begin
        r[BCD_W*i +: BCD_W] = BCD_W'(v % 10);
        v = v / 10;
      end
    end
    return r;
  endfunction

  function automatic logic is_bcd(input logic [BCD_VEC_W-1:0] vec, input int digits);
    logic ok;
    ok = 1'b1;
    for (int i = 0; i < MAX_DIGITS; i++) begin
      if (i < digits && vec[BCD_W*i +: BCD_W] > BCD_DIGIT_MAX) ok = 1'b0;
    end
    return ok;
  endfunction

  // Valid BCD preserves numeric order under a plain unsigned compare.
  function automatic logic bcd_le(input logic [BCD_VEC_W-1:0] a, input logic [BCD_VEC_W-1:0] b);
    return a <= b;
  endfunction

endpackage

// File: rtl/bcd_updown_counter_if.sv
// Control/status bundle of one BCD up/down counter instance.
interface bcd_updown_counter_if
  import bcd_cnt_pkg::*;
#(
  parameter int DIGITS = 2
) ();

  logic                      en;
  logic                      up_dn;
  logic                      load;
  logic [BCD_W*DIGITS-1:0]   load_val;
  logic [BCD_W*DIGITS-1:0]   count;
  logic                      tc;
  logic                      wrap;
  logic                      load_err;

  modport master (
    output en, up_dn, load, load_val,
    input  count, tc, wrap, load_err
  );

  modport slave (
    input  en, up_dn, load, load_val,
    output count, tc, wrap, load_err
  );

endinterface

// File: rtl/bcd_updown_counter_digit.sv
// One BCD decade: steps up/down when enabled by the decade below and reports
// its own carry/borrow. Load beats force, force beats stepping.
module bcd_digit
  import bcd_cnt_pkg::*;
(
  input  logic             clk,
  input  logic             rst,
  input  logic             ci,
  input  logic             up_dn,
  input  logic             ld,
  input  logic [BCD_W-1:0] ld_d,
  input  logic             force_en,
  input  logic [BCD_W-1:0] force_d,
  output logic [BCD_W-1:0] d,
  output logic             co
);

  logic [BCD_W-1:0] d_next;

  always_comb begin
    d_next = d;
    if (ld) begin
      d_next = ld_d;
    end else if (force_en) begin
      d_next = force_d;
    end else if (ci) begin
      if (up_dn) d_next = (d == BCD_DIGIT_MAX) ? '0 : d + 4'd1;
      else       d_next = (d == '0) ? BCD_DIGIT_MAX : d - 4'd1;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) d <= '0;
    else     d <= d_next;
  end

  assign co = ci & (up_dn ? (d == BCD_DIGIT_MAX) : (d == '0));

endmodule

// File: rtl/bcd_updown_counter.sv
// Multi-decade BCD up/down counter with programmable modulus, validated load,
// combinational terminal count for cascading and registered wrap/load_err pulses.
module bcd_updown_counter
  import bcd_cnt_pkg::*;
#(
  parameter int DIGITS    = 2,
  parameter int MAX_COUNT = 59
) (
  input  logic                 clk,
  input  logic                 rst,
  bcd_updown_counter_if.slave  bus
);

  localparam int                   W            = BCD_W * DIGITS;
  localparam logic [BCD_VEC_W-1:0] MAX_BCD_FULL = to_bcd(MAX_COUNT, DIGITS);
  localparam logic [W-1:0]         MAX_BCD      = MAX_BCD_FULL[W-1:0];

  generate
    if (DIGITS < 1 || DIGITS > MAX_DIGITS) begin : g_bad_digits
      $error("bcd_updown_counter: DIGITS must be in 1..8");
    end
    if (MAX_COUNT < 0 || MAX_COUNT >= 10**DIGITS) begin : g_bad_max
      $error("bcd_updown_counter: MAX_COUNT must fit in DIGITS decades");
    end
  endgenerate

  logic [W-1:0]         count;
  logic [BCD_VEC_W-1:0] load_ext;
  logic                 at_max;
  logic                 at_zero;
  logic                 term;
  logic                 step;
  logic                 wrap_now;
  logic                 load_ok;
  logic                 load_take;
  logic [W-1:0]         force_val;
  logic [DIGITS-1:0]    carry;
  logic                 top_co_unused;
  logic                 wrap_p1;
  logic                 load_err_p1;

  always_comb begin
    load_ext         = '0;
    load_ext[W-1:0]  = bus.load_val;
    at_max           = (count == MAX_BCD);
    at_zero          = (count == '0);
    term             = bus.up_dn ? at_max : at_zero;
    // A load request, valid or not, always suppresses counting on that edge.
    step             = bus.en & ~bus.load;
    wrap_now         = step & term;
    load_ok          = is_bcd(load_ext, DIGITS) && bcd_le(load_ext, MAX_BCD_FULL);
    load_take        = bus.load & load_ok;
    force_val        = bus.up_dn ? '0 : MAX_BCD;
  end

  assign carry[0] = step;

  generate
    for (genvar i = 0; i < DIGITS; i++) begin : g_digit
      logic co;
      bcd_digit u_digit (
        .clk      (clk),
        .rst      (rst),
        .ci       (carry[i]),
        .up_dn    (bus.up_dn),
        .ld       (load_take),
        .ld_d     (bus.load_val[BCD_W*i +: BCD_W]),
        .force_en (wrap_now),
        .force_d  (force_val[BCD_W*i +: BCD_W]),
        .d        (count[BCD_W*i +: BCD_W]),
        .co       (co)
      );
      if (i < DIGITS - 1) begin : g_chain
        assign carry[i+1] = co;
      end else begin : g_top
        // The modulus wrap is handled by force, so the top decade's carry is dropped.
        assign top_co_unused = co;
      end
    end
  endgenerate

  // ---- stage p1: event pulses, one cycle after the sampling edge
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wrap_p1     <= 1'b0;
      load_err_p1 <= 1'b0;
    end else begin
      wrap_p1     <= wrap_now;
      load_err_p1 <= bus.load & ~load_ok;
    end
  end

  assign bus.count    = count;
  assign bus.tc       = bus.en & term;
  assign bus.wrap     = wrap_p1;
  assign bus.load_err = load_err_p1;

endmodule

// File: tb/tb_bcd_updown_counter.sv
// Seconds (mod 60) cascaded into minutes (mod 24); both checked against an
// integer reference model driven by directed and random stimulus.
module tb_bcd_updown_counter;

  localparam int MAX_S = 59;
  localparam int MAX_M = 23;

  logic clk = 1'b0;
  logic rst;

  always #5 clk = ~clk;

  bcd_updown_counter_if #(.DIGITS(2)) sec_if ();
  bcd_updown_counter_if #(.DIGITS(2)) min_if ();

  bcd_updown_counter #(.DIGITS(2), .MAX_COUNT(MAX_S)) u_sec (
    .clk (clk),
    .rst (rst),
    .bus (sec_if.slave)
  );

  bcd_updown_counter #(.DIGITS(2), .MAX_COUNT(MAX_M)) u_min (
    .clk (clk),
    .rst (rst),
    .bus (min_if.slave)
  );

  assign min_if.en       = sec_if.tc;
  assign min_if.up_dn    = 1'b1;
  assign min_if.load     = 1'b0;
  assign min_if.load_val = 8'h00;

  int sec_v;
  int min_v;
  int passed;
  int total;
  int wraps_seen;

  function automatic logic [7:0] dec2bcd(input int v);
    return 8'(((v / 10) << 4) | (v % 10));
  endfunction

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) passed++;
    else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
  endtask

  // One clock cycle: drive inputs, check tc mid-cycle, advance the model, check outputs.
  task automatic step(input bit en, input bit up, input bit ld, input logic [7:0] lv);
    bit exp_tc;
    bit exp_wrap;
    bit exp_err;
    int hi;
    int lo;
    sec_if.en       = en;
    sec_if.up_dn    = up;
    sec_if.load     = ld;
    sec_if.load_val = lv;
    @(negedge clk);
    exp_tc = en && (up ? (sec_v == MAX_S) : (sec_v == 0));
    check("tc", sec_if.tc, exp_tc);
    @(posedge clk);
    #1;
    exp_wrap = 1'b0;
    exp_err  = 1'b0;
    if (exp_tc) min_v = (min_v + 1) % (MAX_M + 1);
    if (ld) begin
      hi = int'(lv[7:4]);
      lo = int'(lv[3:0]);
      if (hi <= 9 && lo <= 9 && hi * 10 + lo <= MAX_S) sec_v = hi * 10 + lo;
      else exp_err = 1'b1;
    end else if (en) begin
      if (up) begin
        exp_wrap = (sec_v == MAX_S);
        sec_v    = (sec_v + 1) % (MAX_S + 1);
      end else begin
        exp_wrap = (sec_v == 0);
        sec_v    = (sec_v + MAX_S) % (MAX_S + 1);
      end
    end
    check("count", sec_if.count, dec2bcd(sec_v));
    check("wrap", sec_if.wrap, exp_wrap);
    check("load_err", sec_if.load_err, exp_err);
    check("min_count", min_if.count, dec2bcd(min_v));
    if (sec_if.wrap === 1'b1) wraps_seen++;
  endtask

  initial begin
    bit r_en;
    bit r_up;
    bit r_ld;
    logic [7:0] r_lv;
    passed     = 0;
    total      = 0;
    wraps_seen = 0;
    sec_v      = 0;
    min_v      = 0;
    rst             = 1'b1;
    sec_if.en       = 1'b0;
    sec_if.up_dn    = 1'b1;
    sec_if.load     = 1'b0;
    sec_if.load_val = 8'h00;
    repeat (2) @(posedge clk);
    #1;
    check("reset_count", sec_if.count, 8'h00);
    check("reset_wrap", sec_if.wrap, 1'b0);
    check("reset_load_err", sec_if.load_err, 1'b0);
    check("reset_min", min_if.count, 8'h00);
    rst = 1'b0;

    // Asynchronous reset mid-count with a load_err pulse pending.
    step(1'b0, 1'b1, 1'b1, 8'h37);
    step(1'b0, 1'b1, 1'b1, 8'hAB);
    #2 rst = 1'b1;
    #1;
    check("async_rst_count", sec_if.count, 8'h00);
    check("async_rst_wrap", sec_if.wrap, 1'b0);
    check("async_rst_load_err", sec_if.load_err, 1'b0);
    @(posedge clk);
    #1;
    check("rst_held_count", sec_if.count, 8'h00);
    rst   = 1'b0;
    sec_v = 0;
    min_v = 0;

    // Up through 0x09->0x10 and the 0x59 wrap.
    wraps_seen = 0;
    repeat (61) step(1'b1, 1'b1, 1'b0, 8'h00);
    check("up_wraps", wraps_seen, 1);
    check("up_end", sec_if.count, 8'h01);
    check("up_min", min_if.count, 8'h01);

    // Down from 0x11 through the borrow and the 0x00 wrap.
    step(1'b0, 1'b0, 1'b1, 8'h11);
    wraps_seen = 0;
    repeat (13) step(1'b1, 1'b0, 1'b0, 8'h00);
    check("down_wraps", wraps_seen, 1);
    check("down_end", sec_if.count, 8'h58);

    // Load validation.
    step(1'b0, 1'b1, 1'b1, 8'h42);
    check("load_ok", sec_if.count, 8'h42);
    step(1'b0, 1'b1, 1'b1, 8'h4A);
    step(1'b0, 1'b1, 1'b1, 8'h65);
    step(1'b0, 1'b1, 1'b0, 8'h00);
    check("load_reject_kept", sec_if.count, 8'h42);

    // Load beats enable, then hold.
    step(1'b1, 1'b1, 1'b1, 8'h30);
    repeat (5) step(1'b0, 1'b1, 1'b0, 8'h00);
    check("hold", sec_if.count, 8'h30);

    // Direction change at the top value: no wrap.
    step(1'b0, 1'b1, 1'b1, 8'h59);
    step(1'b1, 1'b0, 1'b0, 8'h00);
    check("dir_change", sec_if.count, 8'h58);

    // Random mix, including illegal load values.
    repeat (400) begin
      r_en = ($urandom_range(0, 3) != 0);
      r_up = $urandom_range(0, 1) == 1;
      r_ld = ($urandom_range(0, 9) == 0);
      if ($urandom_range(0, 1) == 1) r_lv = dec2bcd(int'($urandom_range(0, MAX_S)));
      else r_lv = 8'($urandom);
      step(r_en, r_up, r_ld, r_lv);
    end

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule

// File: doc/bcd_updown_counter.md
Name: bcd_updown_counter

Overview:
Parametrised multi-digit BCD counter and successor to the fixed mod-10 counter. It counts up or down, wraps at a programmable modulus, holds when disabled and accepts a validated parallel load. A combinational terminal-count output lets instances cascade, for example seconds → minutes → hours in the display/timekeeping datapath.

Parameters:
DIGITS, 2, number of BCD decades; count width is 4*DIGITS (legal range 1..8).
MAX_COUNT, 59, decimal terminal value; count sequence is 0..MAX_COUNT; must be < 10**DIGITS (elaboration error otherwise).

Ports:
clk       input   1          rising-edge clock.
rst       input   1          asynchronous reset, active-high.
en        input   1          count enable, one step per clk edge while high.
up_dn     input   1          1 = count up, 0 = count down; sampled on the same edge as en.
load      input   1          synchronous parallel load request.
load_val  input   4*DIGITS   BCD value to load; digit i at bits [4i+3:4i].
count     output  4*DIGITS   current BCD count, registered.
tc        output  1          terminal count, combinational: en & ((up_dn & count==MAX) | (~up_dn & count==0)).
wrap      output  1          registered one-cycle pulse, high the cycle after a wrap occurred.
load_err  output  1          registered one-cycle pulse, high the cycle after a rejected load.

Behaviour:
- Reset: rst high → count=0, wrap=0, load_err=0 immediately, independent of clk. All state is held while rst is high.
- Priority on each rising edge: load > en > hold.
- Load when load=1: if every digit of load_val is ≤ 9 and the value is ≤ MAX_COUNT, count ← load_val. Otherwise count is unchanged and load_err=1 next cycle. This applies regardless of en. A load never sets wrap.
- Count up (en=1, up_dn=1): count ← count+1 in BCD, each digit 9→0 with carry into the next digit. If count==MAX_COUNT, count ← 0 and wrap=1 next cycle.
- Count down (en=1, up_dn=0): BCD decrement, each digit 0→9 with borrow. If count==0, count ← MAX_COUNT and wrap=1 next cycle.
- Hold: en=0 and load=0 → count unchanged; wrap and load_err return to 0.
- wrap and load_err are single-cycle pulses and never stretch. Consecutive wraps (e.g. MAX_COUNT=0 with en held high) produce wrap high on consecutive cycles.
- Latency: count reflects a step or load one edge after sampling. tc is zero-latency, so a downstream stage with en=tc advances on the same edge as the wrap.
- up_dn may change on any cycle; only the value sampled at the edge matters. No state is retained across a direction change.
- count can never leave 0..MAX_COUNT or hold a non-BCD digit.
- Reset asserted mid-count or mid-load: the reset value wins, and pending wrap/load_err pulses are cleared.

Decomposition:
- Package bcd_cnt_pkg:
  - BCD_DIGIT_MAX = 4'd9 and BCD_W = 4.
  - Function to_bcd(int, digits) converts MAX_COUNT to a packed BCD vector.
  - Function is_bcd(vec, digits) performs the load digit check.
  - Function bcd_le(a, b) performs the magnitude compare.
- Sub-module bcd_digit, instantiated DIGITS times in a generate chain:
  - Inputs: ci (step enable from the lower digit), up_dn, ld, ld_d[3:0], force, force_d[3:0].
  - Outputs: d[3:0] and co (step out: up at 9, down at 0).
- Top level computes the terminal-count condition and drives force/force_d with the all-zero or MAX_COUNT digits on wrap. It also handles load validation and the wrap and load_err registers.

Test Plan (DIGITS=2, MAX_COUNT=59 unless noted):
1. Reset: count to 37, then pulse rst between clk edges → count=0x00, wrap=0, load_err=0 before the next edge; count stays 0x00 while rst is held.
2. Up sequence: en=1, up_dn=1 from 0x00 for 61 cycles → 0x09→0x10 carry; tc=1 only while count=0x59; count=0x00 and wrap=1 exactly once after 0x59; then 0x01.
3. Down sequence: en=1, up_dn=0 from 0x11 → 0x10→0x09 borrow; at 0x00 tc=1; next count=0x59 with wrap=1 one cycle later.
4. Load checks:
   - load_val=0x42 with en=0 → count=0x42, load_err=0.
   - load_val=0x4A → count unchanged, load_err=1 for one cycle.
   - load_val=0x65 (>59) → count unchanged, load_err=1.
5. Priority/hold: load=1 with load_val=0x30 and en=1 in the same cycle → count=0x30, no increment. Then en=0 for 5 cycles → count stays 0x30, tc=0.
6. Direction change at the boundary: count=0x59, en=1, up_dn=0 → 0x58, wrap=0. Cascade check: two instances (MAX 59 into MAX 23) with the minutes en tied to the seconds tc → minutes advance only on the 0x59→0x00 seconds edge.
